// File: rtl/sr_mem_arbiter.sv
// rtl/sr_mem_arbiter.sv - round-robin arbiter sharing one memory port between N_CORES cores
//
// Purpose : grants one core request at a time, issues a single AGU_LOAD or
//           AGU_STORE opcode to the memory, waits for load data (with timeout)
//           and returns a one-cycle ack to the granted core.
// Ports   : clk, rst_n (sync, active low)
//           core_req/core_we/core_addr/core_wdata  per-core request bundle (in)
//           core_ack/core_rdata/core_err           per-core completion (out)
//           mem_instr/mem_addr/mem_data            memory command (out)
//           mem_rdata/mem_rvalid                   memory load response (in)
//           busy, grant_id                         status (out)
module sr_mem_arbiter #(
    parameter int         N_CORES    = 4,
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         TIMEOUT    = 16,
    parameter logic [2:0] IDLE_INSTR = 3'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CORES-1:0]         core_req,
    input  logic [N_CORES-1:0]         core_we,
    input  logic [N_CORES*ADDR_W-1:0]  core_addr,
    input  logic [N_CORES*DATA_W-1:0]  core_wdata,
    output logic [N_CORES-1:0]         core_ack,
    output logic [DATA_W-1:0]          core_rdata,
    output logic                       core_err,
    output logic [2:0]                 mem_instr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_rvalid,
    output logic                       busy,
    output logic [$clog2(N_CORES)-1:0] grant_id
);

    localparam int IDW  = $clog2(N_CORES);
    localparam int CNTW = $clog2(TIMEOUT);

    localparam logic [2:0] AGU_LOAD  = 3'b001;
    localparam logic [2:0] AGU_STORE = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_CORES-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [IDW-1:0]      grant_q, grant_d;
    // Last granted core; reset to N_CORES-1 so that core 0 is searched first.
    logic [IDW-1:0]      last_q, last_d;
    logic                we_q, we_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    logic                found;
    logic [IDW-1:0]      win;

    // Round-robin search starting just after the last grant, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            if (!found && core_req[(int'(last_q) + k) % N_CORES]) begin
                found = 1'b1;
                win   = IDW'((int'(last_q) + k) % N_CORES);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = IDLE_INSTR;
        addr_d  = addr_q;
        data_d  = data_q;
        ack_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = win;
                    last_d  = win;
                    we_d    = core_we[win];
                    addr_d  = core_addr[int'(win)*ADDR_W +: ADDR_W];
                    data_d  = core_wdata[int'(win)*DATA_W +: DATA_W];
                    // Opcode is registered here so it appears during ISSUE only.
                    instr_d = core_we[win] ? AGU_STORE : AGU_LOAD;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d        = mem_rdata;
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_DONE;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    rdata_d        = '1;
                    err_d          = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= IDLE_INSTR;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= IDW'(N_CORES - 1);
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core_ack   = ack_q;
    assign core_rdata = rdata_q;
    assign core_err   = err_q;
    assign mem_instr  = instr_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule
